// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg: shared state encoding, register offsets and bit indices for the inference controller
package nn_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, FINISH, ABORT} state_e;
  localparam logic [3:0] CTRL_OFS = 4'd0;
  localparam logic [3:0] STAT_OFS = 4'd4;
  localparam logic [3:0] TO_OFS   = 4'd8;
  localparam logic [3:0] CYC_OFS  = 4'd12;
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_TO       = 2;
  localparam int ST_OVR      = 3;
endpackage

// File: rtl/nn_ctrl_regs.sv
// nn_ctrl_regs: address decode, CTRL/STATUS/TIMEOUT storage and read mux
//   addr_i/we_i/re_i/wd_i : CPU bus in; rd_o/hit_o : combinational read data and decode hit
//   busy_i/set_*_i/cycles_i : status events and live values from the sequencer
//   start_o : CTRL write with START set; irq_en_o/timeout_o : register contents
module nn_ctrl_regs import nn_ctrl_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = 32'd1004,
  parameter int TO_W = 16,
  parameter logic [TO_W-1:0] TO_DEFAULT = 16'd4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     addr_i,
  input  logic            we_i,
  input  logic            re_i,
  input  logic [31:0]     wd_i,
  output logic [31:0]     rd_o,
  output logic            hit_o,
  input  logic            busy_i,
  input  logic            set_done_i,
  input  logic            set_to_i,
  input  logic            set_ovr_i,
  input  logic [TO_W-1:0] cycles_i,
  output logic            start_o,
  output logic            irq_en_o,
  output logic [TO_W-1:0] timeout_o
);
  logic [31:0] diff;
  logic [3:0] ofs;
  logic wr;
  logic irq_en_q, irq_en_d;
  logic [3:1] st_q, st_d;
  logic [TO_W-1:0] to_q, to_d;
  logic unused;
  assign diff = addr_i - BASE_ADDR;
  assign ofs = diff[3:0];
  assign hit_o = addr_i >= BASE_ADDR && diff <= 32'd12 && addr_i[1:0] == 2'b00;
  assign wr = we_i & hit_o;
  assign start_o = wr && ofs == CTRL_OFS && wd_i[CTRL_START];
  assign irq_en_o = irq_en_q;
  assign timeout_o = to_q;
  assign unused = ^{re_i, wd_i[31:TO_W]};
  // set events are OR-ed in after the W1C mask so a simultaneous set survives the clear
  always_comb begin
    irq_en_d = wr && ofs == CTRL_OFS ? wd_i[CTRL_IRQ_EN] : irq_en_q;
    to_d = wr && ofs == TO_OFS ? wd_i[TO_W-1:0] : to_q;
    st_d = (st_q & ~(wr && ofs == STAT_OFS ? wd_i[ST_OVR:ST_DONE] : 3'b000)) | {set_ovr_i, set_to_i, set_done_i};
  end
  always_comb begin
    rd_o = !hit_o ? 32'd0 :
           ofs == CTRL_OFS ? {30'd0, irq_en_q, 1'b0} :
           ofs == STAT_OFS ? {28'd0, st_q, busy_i} :
           ofs == TO_OFS   ? 32'(to_q) : 32'(cycles_i);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      st_q <= '0;
      to_q <= TO_DEFAULT;
    end else begin
      irq_en_q <= irq_en_d;
      st_q <= st_d;
      to_q <= to_d;
    end
  end
endmodule

// File: rtl/nn_inference_ctrl.sv
// nn_inference_ctrl: memory-mapped start/timeout/interrupt sequencer for the neural engine
//   cpu_addr/cpu_we/cpu_re/cpu_wd/cpu_rd/cpu_hit : register bus (CTRL, STATUS, TIMEOUT, CYCLES)
//   run_inference : instruction start strobe; nn_start/nn_abort : one-cycle engine pulses
//   nn_ready : engine done level; busy : inference in flight; irq : one-cycle interrupt
//   NN_CTRL_PERF_EN : when defined, CYCLES exposes the RUN cycle count; otherwise it reads 0
module nn_inference_ctrl import nn_ctrl_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = 32'd1004,
  parameter int TO_W = 16,
  parameter logic [TO_W-1:0] TO_DEFAULT = 16'd4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_hit,
  input  logic        run_inference,
  output logic        nn_start,
  output logic        nn_abort,
  input  logic        nn_ready,
  output logic        busy,
  output logic        irq
);
  state_e state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc, timeout, cycles;
  logic rdy_q, ctrl_start, start_req, irq_en, rise, to_hit;
  assign start_req = ctrl_start | run_inference;
  assign rise = nn_ready & ~rdy_q;
  assign cnt_inc = cnt_q + TO_W'(1);
  assign to_hit = timeout != '0 && cnt_inc == timeout;
  assign nn_start = state_q == LAUNCH;
  assign nn_abort = state_q == ABORT;
  assign busy = state_q != IDLE;
  assign irq = (state_q == FINISH || state_q == ABORT) && irq_en;
`ifdef NN_CTRL_PERF_EN
  assign cycles = cnt_q;
`else
  assign cycles = '0;
`endif
  // completion is checked before the timeout so a same-cycle rise resolves as done
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = start_req ? LAUNCH : IDLE;
        cnt_d = start_req ? '0 : cnt_q;
      end
      LAUNCH: state_d = RUN;
      RUN: begin
        cnt_d = &cnt_q ? cnt_q : cnt_inc;
        state_d = rise ? FINISH : to_hit ? ABORT : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdy_q <= nn_ready;
    end
  end
  nn_ctrl_regs #(.BASE_ADDR(BASE_ADDR), .TO_W(TO_W), .TO_DEFAULT(TO_DEFAULT)) u_regs (
    .clk(clk),
    .reset(reset),
    .addr_i(cpu_addr),
    .we_i(cpu_we),
    .re_i(cpu_re),
    .wd_i(cpu_wd),
    .rd_o(cpu_rd),
    .hit_o(cpu_hit),
    .busy_i(busy),
    .set_done_i(state_q == FINISH),
    .set_to_i(state_q == ABORT),
    .set_ovr_i(start_req && state_q != IDLE),
    .cycles_i(cycles),
    .start_o(ctrl_start),
    .irq_en_o(irq_en),
    .timeout_o(timeout)
  );
endmodule

// File: tb/tb_nn_inference_ctrl.sv
// tb_nn_inference_ctrl: directed vectors and sequences for the inference controller
module tb_nn_inference_ctrl;
`ifdef NN_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_we = 1'b0;
  logic cpu_re = 1'b0;
  logic run_inference = 1'b0;
  logic nn_ready = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wd = 32'd0;
  logic [31:0] cpu_rd;
  logic cpu_hit, nn_start, nn_abort, busy, irq;
  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_abort = 0;
  int n_irq = 0;
  int s0, a0, i0;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] rd;
    logic hit;
  } vec_t;
  vec_t vecs[8];
  nn_inference_ctrl dut (
    .clk(clk),
    .reset(reset),
    .cpu_addr(cpu_addr),
    .cpu_we(cpu_we),
    .cpu_re(cpu_re),
    .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd),
    .cpu_hit(cpu_hit),
    .run_inference(run_inference),
    .nn_start(nn_start),
    .nn_abort(nn_abort),
    .nn_ready(nn_ready),
    .busy(busy),
    .irq(irq)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (nn_start) n_start++;
    if (nn_abort) n_abort++;
    if (irq) n_irq++;
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cpu_addr = a;
    cpu_wd = d;
    cpu_we = 1'b1;
    tick(1);
    cpu_we = 1'b0;
  endtask
  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    cpu_addr = a;
    cpu_re = 1'b1;
    #1;
    chk(name, cpu_rd, exp);
    cpu_re = 1'b0;
  endtask
  task automatic pulse_run();
    run_inference = 1'b1;
    tick(1);
    run_inference = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{32'd1004, 32'd0, 1'b1};
    vecs[1] = '{32'd1008, 32'd0, 1'b1};
    vecs[2] = '{32'd1012, 32'd4096, 1'b1};
    vecs[3] = '{32'd1016, 32'd0, 1'b1};
    vecs[4] = '{32'd1000, 32'd0, 1'b0};
    vecs[5] = '{32'd1020, 32'd0, 1'b0};
    vecs[6] = '{32'd1006, 32'd0, 1'b0};
    vecs[7] = '{32'd1005, 32'd0, 1'b0};
    tick(2);
    reset = 1'b0;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(nn_start), 32'd0);
    chk("rst_abort", 32'(nn_abort), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cpu_addr = vecs[i].addr;
      #1;
      chk($sformatf("vec%0d_rd", i), cpu_rd, vecs[i].rd);
      chk($sformatf("vec%0d_hit", i), 32'(cpu_hit), 32'(vecs[i].hit));
    end
    s0 = n_start;
    i0 = n_irq;
    wr(32'd1004, 32'd3);
    chk("t2_start", 32'(nn_start), 32'd1);
    rd("t2_ctrl", 32'd1004, 32'd2);
    tick(10);
    chk("t2_start_gone", 32'(nn_start), 32'd0);
    nn_ready = 1'b1;
    tick(1);
    chk("t2_irq", 32'(irq), 32'd1);
    chk("t2_busy_fin", 32'(busy), 32'd1);
    tick(1);
    nn_ready = 1'b0;
    chk("t2_busy_idle", 32'(busy), 32'd0);
    rd("t2_status", 32'd1008, 32'd2);
    rd("t2_cycles", 32'd1016, PERF ? 32'd10 : 32'd0);
    chk("t2_nstart", 32'(n_start - s0), 32'd1);
    chk("t2_nirq", 32'(n_irq - i0), 32'd1);
    wr(32'd1004, 32'd0);
    wr(32'd1008, 32'd14);
    wr(32'd1012, 32'd5);
    a0 = n_abort;
    i0 = n_irq;
    pulse_run();
    chk("t3_start", 32'(nn_start), 32'd1);
    tick(5);
    chk("t3_no_early_abort", 32'(nn_abort), 32'd0);
    tick(1);
    chk("t3_abort", 32'(nn_abort), 32'd1);
    chk("t3_irq", 32'(irq), 32'd0);
    tick(1);
    chk("t3_busy_idle", 32'(busy), 32'd0);
    rd("t3_status", 32'd1008, 32'd4);
    rd("t3_cycles", 32'd1016, PERF ? 32'd5 : 32'd0);
    chk("t3_nabort", 32'(n_abort - a0), 32'd1);
    chk("t3_nirq", 32'(n_irq - i0), 32'd0);
    wr(32'd1008, 32'd14);
    a0 = n_abort;
    pulse_run();
    tick(5);
    nn_ready = 1'b1;
    tick(1);
    chk("t4_busy_fin", 32'(busy), 32'd1);
    chk("t4_abort", 32'(nn_abort), 32'd0);
    tick(1);
    nn_ready = 1'b0;
    rd("t4_status", 32'd1008, 32'd2);
    chk("t4_nabort", 32'(n_abort - a0), 32'd0);
    wr(32'd1008, 32'd14);
    wr(32'd1012, 32'd0);
    s0 = n_start;
    pulse_run();
    tick(2);
    run_inference = 1'b1;
    cpu_addr = 32'd1008;
    cpu_wd = 32'd8;
    cpu_we = 1'b1;
    tick(1);
    run_inference = 1'b0;
    cpu_we = 1'b0;
    rd("t5_ovr_set_wins", 32'd1008, 32'd9);
    nn_ready = 1'b1;
    tick(2);
    nn_ready = 1'b0;
    chk("t5_busy_idle", 32'(busy), 32'd0);
    rd("t5_status", 32'd1008, 32'd10);
    chk("t5_nstart", 32'(n_start - s0), 32'd1);
    wr(32'd1008, 32'd8);
    rd("t5_ovr_clr", 32'd1008, 32'd2);
    wr(32'd1008, 32'd14);
    nn_ready = 1'b1;
    tick(1);
    s0 = n_start;
    a0 = n_abort;
    run_inference = 1'b1;
    wr(32'd1004, 32'd1);
    run_inference = 1'b0;
    chk("t6_start", 32'(nn_start), 32'd1);
    tick(11);
    chk("t6_busy_stale_ready", 32'(busy), 32'd1);
    rd("t6_status_run", 32'd1008, 32'd1);
    rd("t6_cycles", 32'd1016, PERF ? 32'd10 : 32'd0);
    reset = 1'b1;
    tick(1);
    chk("t6_busy_rst", 32'(busy), 32'd0);
    chk("t6_abort_rst", 32'(nn_abort), 32'd0);
    reset = 1'b0;
    nn_ready = 1'b0;
    rd("t6_status_rst", 32'd1008, 32'd0);
    rd("t6_timeout_rst", 32'd1012, 32'd4096);
    rd("t6_ctrl_rst", 32'd1004, 32'd0);
    rd("t6_cycles_rst", 32'd1016, 32'd0);
    chk("t6_nstart", 32'(n_start - s0), 32'd1);
    chk("t6_nabort", 32'(n_abort - a0), 32'd0);
    tick(2);
    chk("t6_idle", 32'(busy), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
